// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy two-tube coin payout controller with stock tracking
//
// Pays a requested amount (Rs.5 units) as Rs.10 then Rs.5 eject pulses, limited by
// tube stock, and flags a short payment when stock runs out.
// Optional feature macro: CHANGE_AUDIT_EN (adds total_paid / short_count).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, amount         payout request and amount, sampled in IDLE
//   refill, refill5/10  tube refill strobe and coin counts, sampled in IDLE
//   busy, done, short   transaction status; short is valid with done
//   paid                units paid in current/last transaction
//   eject5, eject10     solenoid drives
//   stock5, stock10     current tube stock
//   total_paid          (audit) cumulative units ejected since reset, wrapping
//   short_count         (audit) number of short completions, saturating
module change_dispenser #(
    parameter int AMT_W     = 4,
    parameter int CNT_W     = 8,
    parameter int INIT_5    = 20,
    parameter int INIT_10   = 20,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill5,
    input  logic [CNT_W-1:0] refill10,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] paid,
    output logic             eject5,
    output logic             eject10,
    output logic [CNT_W-1:0] stock5,
`ifdef CHANGE_AUDIT_EN
    output logic [CNT_W-1:0] stock10,
    output logic [15:0]      total_paid,
    output logic [7:0]       short_count
`else
    output logic [CNT_W-1:0] stock10
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_EJECT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             acc_q;      // request latched in IDLE; DECIDE follows one cycle later
    logic [AMT_W-1:0] rem_q;
    logic [7:0]       cnt_q;      // pulse / gap cycle counter
    logic             busy_q;
    logic             done_q;
    logic             short_q;
    logic [AMT_W-1:0] paid_q;
    logic             ej5_q;
    logic             ej10_q;
    logic [CNT_W-1:0] stock5_q;
    logic [CNT_W-1:0] stock10_q;
`ifdef CHANGE_AUDIT_EN
    logic [15:0]      total_paid_q;
    logic [7:0]       short_count_q;
`endif

    // Saturating refill sums
    logic [CNT_W:0]   sum5;
    logic [CNT_W:0]   sum10;
    logic [CNT_W-1:0] stock5_d;
    logic [CNT_W-1:0] stock10_d;

    always_comb begin
        sum5      = {1'b0, stock5_q} + {1'b0, refill5};
        sum10     = {1'b0, stock10_q} + {1'b0, refill10};
        stock5_d  = sum5[CNT_W]  ? {CNT_W{1'b1}} : sum5[CNT_W-1:0];
        stock10_d = sum10[CNT_W] ? {CNT_W{1'b1}} : sum10[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            paid_q    <= '0;
            ej5_q     <= 1'b0;
            ej10_q    <= 1'b0;
            stock5_q  <= CNT_W'(INIT_5);
            stock10_q <= CNT_W'(INIT_10);
`ifdef CHANGE_AUDIT_EN
            total_paid_q  <= '0;
            short_count_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_q) begin
                        acc_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_DECIDE;
                    end else begin
                        if (refill) begin
                            stock5_q  <= stock5_d;
                            stock10_q <= stock10_d;
                        end
                        if (req) begin
                            acc_q   <= 1'b1;
                            rem_q   <= amount;
                            paid_q  <= '0;
                            short_q <= 1'b0;
                        end
                    end
                end
                S_DECIDE: begin
                    if (rem_q >= AMT_W'(2) && stock10_q != '0) begin
                        ej10_q    <= 1'b1;
                        stock10_q <= stock10_q - 1'b1;
                        rem_q     <= rem_q - AMT_W'(2);
                        paid_q    <= paid_q + AMT_W'(2);
                        cnt_q     <= 8'(PULSE_LEN - 1);
                        state_q   <= S_EJECT;
`ifdef CHANGE_AUDIT_EN
                        total_paid_q <= total_paid_q + 16'd2;
`endif
                    end else if (rem_q != '0 && stock5_q != '0) begin
                        ej5_q    <= 1'b1;
                        stock5_q <= stock5_q - 1'b1;
                        rem_q    <= rem_q - AMT_W'(1);
                        paid_q   <= paid_q + AMT_W'(1);
                        cnt_q    <= 8'(PULSE_LEN - 1);
                        state_q  <= S_EJECT;
`ifdef CHANGE_AUDIT_EN
                        total_paid_q <= total_paid_q + 16'd1;
`endif
                    end else begin
                        // Either fully paid or out of usable coins
                        done_q  <= 1'b1;
                        short_q <= (rem_q != '0);
                        state_q <= S_DONE;
`ifdef CHANGE_AUDIT_EN
                        if (rem_q != '0 && short_count_q != 8'hFF)
                            short_count_q <= short_count_q + 8'd1;
`endif
                    end
                end
                S_EJECT: begin
                    if (cnt_q == '0) begin
                        ej5_q   <= 1'b0;
                        ej10_q  <= 1'b0;
                        cnt_q   <= 8'(GAP_LEN - 1);
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) state_q <= S_DECIDE;
                    else             cnt_q   <= cnt_q - 8'd1;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign short   = short_q;
    assign paid    = paid_q;
    assign eject5  = ej5_q;
    assign eject10 = ej10_q;
    assign stock5  = stock5_q;
    assign stock10 = stock10_q;
`ifdef CHANGE_AUDIT_EN
    assign total_paid  = total_paid_q;
    assign short_count = short_count_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;
    localparam int AMT_W     = 4;
    localparam int CNT_W     = 8;
    localparam int PULSE_LEN = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             refill = 1'b0;
    logic [CNT_W-1:0] refill5 = '0;
    logic [CNT_W-1:0] refill10 = '0;
    logic             busy, done, short, eject5, eject10;
    logic [AMT_W-1:0] paid;
    logic [CNT_W-1:0] stock5, stock10;

    change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_5(20), .INIT_10(20),
        .PULSE_LEN(PULSE_LEN), .GAP_LEN(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .amount(amount),
        .refill(refill), .refill5(refill5), .refill10(refill10),
        .busy(busy), .done(done), .short(short), .paid(paid),
        .eject5(eject5), .eject10(eject10), .stock5(stock5), .stock10(stock10)
    );

    always #5 clk = ~clk;

    typedef struct {
        int paid;
        int shrt;
        int s5;
        int s10;
        int n10;
        int n5;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse widths, coin counts, and scoreboard compare on done
    int n10 = 0, n5 = 0, w10 = 0, w5 = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            n10 = 0; n5 = 0; w10 = 0; w5 = 0;
        end else begin
            if (eject5 && eject10) chk("eject_exclusive", 1, 0);
            if ((eject5 || eject10) && !busy) chk("eject_without_busy", 1, 0);
            if (eject10) begin
                if (w10 == 0) n10++;
                w10++;
            end else begin
                if (w10 != 0) chk("pulse10_width", w10, PULSE_LEN);
                w10 = 0;
            end
            if (eject5) begin
                if (w5 == 0) n5++;
                w5++;
            end else begin
                if (w5 != 0) chk("pulse5_width", w5, PULSE_LEN);
                w5 = 0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("paid", int'(paid), e.paid);
                    chk("short", int'(short), e.shrt);
                    chk("stock5", int'(stock5), e.s5);
                    chk("stock10", int'(stock10), e.s10);
                    chk("coins10", n10, e.n10);
                    chk("coins5", n5, e.n5);
                    chk("busy_with_done", int'(busy), 1);
                end
                n10 = 0; n5 = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input int p, input int s, input int s5,
                         input int s10, input int e10, input int e5);
        exp_t e;
        e.paid = p; e.shrt = s; e.s5 = s5; e.s10 = s10; e.n10 = e10; e.n5 = e5;
        q.push_back(e);
        req = 1'b1;
        amount = AMT_W'(a);
        tick;
        req = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!busy && n < 10) begin tick; n++; end
        chk("busy_rise", int'(busy), 1);
        n = 0;
        while (busy && n < 400) begin tick; n++; end
        chk("busy_fall_in_time", int'(busy), 0);
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int bc, dn, n;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_paid", int'(paid), 0);
        chk("rst_eject", int'(eject5 | eject10), 0);
        chk("rst_stock5", int'(stock5), 20);
        chk("rst_stock10", int'(stock10), 20);
        tick;

        // Rs.25: 10,10,5 with first rise two edges after the request edge
        issue(5, 5, 0, 19, 18, 2, 1);
        chk("busy_at_k", int'(busy), 0);
        tick;
        chk("busy_at_k1", int'(busy), 1);
        chk("eject_at_k1", int'(eject10 | eject5), 0);
        tick;
        chk("eject10_at_k2", int'(eject10), 1);
        chk("stock10_dec_at_k2", int'(stock10), 19);
        chk("paid_at_k2", int'(paid), 2);
        wait_done;

        // amount 0: done two cycles after request, busy exactly two cycles
        issue(0, 0, 0, 19, 18, 0, 0);
        bc = 0; dn = 0;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (busy) bc++;
            if (done) dn = i;
        end
        chk("zero_busy_cycles", bc, 2);
        chk("zero_done_cycle", dn, 2);

        // Max amount; req and refill during payout must be ignored
        issue(15, 15, 0, 18, 11, 7, 1);
        repeat (6) tick;
        req = 1'b1; amount = 4'd1; refill = 1'b1; refill5 = 8'd100; refill10 = 8'd100;
        repeat (3) tick;
        req = 1'b0; refill = 1'b0; refill5 = '0; refill10 = '0;
        wait_done;

        issue(15, 15, 0, 17, 4, 7, 1);
        wait_done;
        // Rs.10 runs out mid-transaction
        issue(9, 9, 0, 16, 0, 4, 1);
        wait_done;
        // No Rs.10 stock: three Rs.5 coins
        issue(3, 3, 0, 13, 0, 0, 3);
        wait_done;
        issue(13, 13, 0, 0, 0, 0, 13);
        wait_done;

        refill = 1'b1; refill10 = 8'd1; refill5 = 8'd0;
        tick;
        refill = 1'b0; refill10 = '0;
        chk("refill_stock10", int'(stock10), 1);
        chk("refill_stock5", int'(stock5), 0);

        // Odd amount, one Rs.10, no Rs.5: pay 2 then short
        issue(3, 2, 1, 0, 0, 1, 0);
        wait_done;
        issue(1, 0, 1, 0, 0, 0, 0);
        wait_done;

        // Refill on the same edge as the request is visible to DECIDE
        refill = 1'b1; refill10 = 8'd3;
        issue(4, 4, 0, 0, 1, 2, 0);
        refill = 1'b0; refill10 = '0;
        wait_done;
        issue(4, 2, 1, 0, 0, 1, 0);
        wait_done;

        // Reset in the middle of an eject pulse
        refill = 1'b1; refill5 = 8'd5;
        tick;
        refill = 1'b0; refill5 = '0;
        req = 1'b1; amount = 4'd3;
        tick;
        req = 1'b0;
        n = 0;
        while (!eject5 && n < 10) begin tick; n++; end
        chk("abort_eject_start", int'(eject5), 1);
        rst = 1'b1;
        tick;
        chk("abort_eject_low", int'(eject5 | eject10), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_stock5", int'(stock5), 20);
        chk("abort_stock10", int'(stock10), 20);
        chk("abort_paid", int'(paid), 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("abort_no_done", int'(done), 0);
        end

        // Saturating refill
        refill = 1'b1; refill5 = 8'd250;
        tick;
        chk("refill_sat5", int'(stock5), 255);
        refill5 = 8'd10;
        tick;
        refill = 1'b0; refill5 = '0;
        chk("refill_sat5_hold", int'(stock5), 255);
        chk("refill_sat_stock10", int'(stock10), 20);

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
